// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit for the ALU. It performs SLL, SRL or SRA by any amount.
// A narrow shifter of at most STEP_MAX bits per cycle keeps the datapath small.
module shift_sequencer #(
   parameter int unsigned N        = 32,
   parameter int unsigned STEP_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         a,
   input  logic [$clog2(N)-1:0] shamt,
   input  logic [1:0]           op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         y,
   output logic                 busy
);

   localparam int unsigned SW = $clog2(N);

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_SRA  = 2'b10;
   localparam logic [1:0] OP_PASS = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_t;

   state_t          r_state;
   logic [N-1:0]    r_acc;
   logic [SW-1:0]   r_remaining;
   logic [1:0]      r_op_q;

   logic [SW-1:0]   w_step;
   logic            w_last_step;
   logic [N-1:0]    w_shifted;

   assign w_last_step = (r_remaining <= SW'(STEP_MAX));
   assign w_step      = w_last_step ? r_remaining : SW'(STEP_MAX);

   // Narrow shifter: only distances 1..STEP_MAX are built, and the sign is taken from acc[N-1].
   always_comb begin
      w_shifted = r_acc;
      for (int unsigned k = 1; k <= STEP_MAX; k++) begin
         if (w_step == SW'(k)) begin
            case (r_op_q)
               OP_SLL:  w_shifted = r_acc << k;
               OP_SRL:  w_shifted = r_acc >> k;
               OP_SRA:  w_shifted = $signed(r_acc) >>> k;
               default: w_shifted = r_acc;
            endcase
         end
      end
   end

   // Sequencer FSM. All handshake outputs and y are registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_remaining <= '0;
         r_op_q      <= OP_SLL;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         y           <= '0;
         busy        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  r_acc    <= a;
                  r_op_q   <= op;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if ((op == OP_PASS) || (shamt == '0)) begin
                     r_remaining <= '0;
                     r_state     <= S_DONE;
                     out_valid   <= 1'b1;
                     y           <= a;
                  end else begin
                     r_remaining <= shamt;
                     r_state     <= S_SHIFT;
                  end
               end
            end

            S_SHIFT: begin
               r_acc       <= w_shifted;
               r_remaining <= r_remaining - w_step;
               if (w_last_step) begin
                  r_state   <= S_DONE;
                  out_valid <= 1'b1;
                  y         <= w_shifted;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  r_state   <= S_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end

            default: begin
               r_state   <= S_IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer. It uses hand-computed results and latencies,
// and it checks backpressure, asynchronous reset and back-to-back issue.
module tb_shift_sequencer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [4:0]  shamt;
   logic [1:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   shift_sequencer #(.N(32), .STEP_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .shamt     (shamt),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Issue one request, then count edges from acceptance until out_valid rises.
   task automatic issue_and_wait(input logic [31:0] ta, input logic [4:0] ts, input logic [1:0] to,
                                 input int exp_lat, input logic [31:0] exp_y, input string tag);
      int edges;
      @(negedge clk);
      check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
      a = ta; shamt = ts; op = to; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges = 1;
      check({tag, " busy after accept"}, 32'(busy), 32'd1);
      while (!out_valid && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      check({tag, " latency"}, 32'(edges), 32'(exp_lat));
      check({tag, " y"}, y, exp_y);
   endtask

   task automatic handshake(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " out_valid dropped"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
      check({tag, " busy cleared"}, 32'(busy), 32'd0);
   endtask

   logic [31:0] b2b_a   [4];
   logic [4:0]  b2b_sh  [4];
   logic [1:0]  b2b_op  [4];
   logic [31:0] b2b_exp [4];

   initial begin
      int issued;
      int got;
      int cyc;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; shamt = '0; op = '0;
      #12;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset y", y, 32'h0);
      check("reset busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      issue_and_wait(32'h0000_0001, 5'd5, 2'b00, 3, 32'h0000_0020, "sll5");
      check("sll5 busy before hs", 32'(busy), 32'd1);
      handshake("sll5");

      issue_and_wait(32'h8000_0000, 5'd31, 2'b10, 9, 32'hFFFF_FFFF, "sra31");
      handshake("sra31");
      issue_and_wait(32'h8000_0000, 5'd31, 2'b01, 9, 32'h0000_0001, "srl31");
      handshake("srl31");
      issue_and_wait(32'h7FFF_FFFF, 5'd30, 2'b10, 9, 32'h0000_0001, "sra_pos");
      handshake("sra_pos");
      issue_and_wait(32'h8000_0001, 5'd4, 2'b00, 2, 32'h0000_0010, "sll4");
      handshake("sll4");
      issue_and_wait(32'hDEAD_BEEF, 5'd0, 2'b00, 1, 32'hDEAD_BEEF, "sh0");
      handshake("sh0");
      issue_and_wait(32'h1234_5678, 5'd7, 2'b11, 1, 32'h1234_5678, "pass");
      handshake("pass");

      // Backpressure: the result must hold and new requests must be ignored.
      issue_and_wait(32'hF000_0000, 5'd4, 2'b01, 2, 32'h0F00_0000, "bp");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = 32'h5555_5555; shamt = 5'd1; op = 2'b00;
         @(posedge clk); #1;
         check("bp y stable", y, 32'h0F00_0000);
         check("bp out_valid held", 32'(out_valid), 32'd1);
         check("bp in_ready low", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      handshake("bp");
      check("bp y holds in idle", y, 32'h0F00_0000);

      // Asynchronous reset while shifting.
      @(negedge clk);
      a = 32'h0000_0001; shamt = 5'd20; op = 2'b00; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst out_valid", 32'(out_valid), 32'd0);
      check("arst y", y, 32'h0);
      check("arst in_ready", 32'(in_ready), 32'd1);
      check("arst busy", 32'(busy), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      issue_and_wait(32'h0000_0003, 5'd1, 2'b00, 2, 32'h0000_0006, "post_rst");
      handshake("post_rst");

      // Back-to-back: issue whenever in_ready is high, with out_ready held high.
      b2b_a[0] = 32'h0000_00FF; b2b_sh[0] = 5'd8;  b2b_op[0] = 2'b00; b2b_exp[0] = 32'h0000_FF00;
      b2b_a[1] = 32'hF000_0000; b2b_sh[1] = 5'd7;  b2b_op[1] = 2'b10; b2b_exp[1] = 32'hFFE0_0000;
      b2b_a[2] = 32'h8000_0000; b2b_sh[2] = 5'd16; b2b_op[2] = 2'b01; b2b_exp[2] = 32'h0000_8000;
      b2b_a[3] = 32'hCAFE_BABE; b2b_sh[3] = 5'd31; b2b_op[3] = 2'b11; b2b_exp[3] = 32'hCAFE_BABE;
      issued = 0; got = 0; cyc = 0;
      out_ready = 1'b1;
      while (got < 4 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (out_valid) begin
            check($sformatf("b2b y%0d", got), y, b2b_exp[got]);
            got++;
         end
         if (in_ready && issued < 4) begin
            a = b2b_a[issued]; shamt = b2b_sh[issued]; op = b2b_op[issued];
            in_valid = 1'b1;
            issued++;
         end else begin
            in_valid = 1'b0;
         end
      end
      check("b2b result count", 32'(got), 32'd4);
      in_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("b2b no extra result", 32'(out_valid), 32'd0);
      end
      out_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
